// File: rtl/game_flow_fsm.sv
// Game-flow controller for Tetris: start / play / pause / over sequencing with
// edge-qualified keys, a board-clear pulse and a tick-timed end-screen hold.
module game_flow_fsm #(
    parameter int unsigned                KEYCODE_W       = 8,
    parameter logic        [KEYCODE_W-1:0] KEY_START       = 8'h2C,
    parameter logic        [KEYCODE_W-1:0] KEY_PAUSE       = 8'h13,
    parameter logic        [KEYCODE_W-1:0] KEY_RESTART     = 8'h15,
    parameter int unsigned                OVER_HOLD_TICKS = 120
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic                 tick,
    input  logic                 gameOver,
    output logic [1:0]           outputState,
    output logic                 playEnable,
    output logic                 clearBoard,
    output logic                 holdDone
);

    localparam int unsigned HoldW = (OVER_HOLD_TICKS > 0) ? $clog2(OVER_HOLD_TICKS + 1) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(OVER_HOLD_TICKS);

    // Encoding doubles as the screen-select code driven to the VGA mux.
    typedef enum logic [1:0] {
        StOver  = 2'b00,
        StStart = 2'b01,
        StPlay  = 2'b10,
        StPause = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [KEYCODE_W-1:0] prev_key_q;
    logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
    logic                 clear_board_q, clear_board_d;
    logic                 hit_start, hit_pause, hit_restart;
    logic                 hold_zero;

    assign hit_start   = (keycode == KEY_START)   && (prev_key_q != KEY_START);
    assign hit_pause   = (keycode == KEY_PAUSE)   && (prev_key_q != KEY_PAUSE);
    assign hit_restart = (keycode == KEY_RESTART) && (prev_key_q != KEY_RESTART);
    assign hold_zero   = (hold_cnt_q == '0);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStart: begin
                if (hit_start) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (gameOver) begin
                    state_d = StOver;
                end else if (hit_pause) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (hit_restart) begin
                    state_d = StStart;
                end else if (hit_pause) begin
                    state_d = StPlay;
                end
            end
            StOver: begin
                if (hold_zero && (hit_start || hit_restart)) begin
                    state_d = StStart;
                end
            end
            default: state_d = StStart;
        endcase
    end

    // Hold counter and clear-pulse next values; the load wins over a coincident tick.
    always_comb begin
        hold_cnt_d    = hold_cnt_q;
        clear_board_d = 1'b0;
        if ((state_q == StPlay) && (state_d == StOver)) begin
            hold_cnt_d = HoldLoad;
        end else if ((state_q == StOver) && tick && !hold_zero) begin
            hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
        if ((state_q == StStart) && (state_d == StPlay)) begin
            clear_board_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_key_q    <= '0;
            hold_cnt_q    <= '0;
            clear_board_q <= 1'b0;
        end else begin
            prev_key_q    <= keycode;
            hold_cnt_q    <= hold_cnt_d;
            clear_board_q <= clear_board_d;
        end
    end

    // Output decode
    always_comb begin
        outputState = state_q;
        playEnable  = (state_q == StPlay);
        holdDone    = (state_q == StOver) && hold_zero;
        clearBoard  = clear_board_q;
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm: directed scenarios then randomized keys,
// ticks, gameOver and async resets, all compared against a behavioural model.
module tb_game_flow_fsm;

    localparam int unsigned Hold     = 3;
    localparam logic [7:0]  KStart   = 8'h2C;
    localparam logic [7:0]  KPause   = 8'h13;
    localparam logic [7:0]  KRestart = 8'h15;

    localparam int MStart = 0;
    localparam int MPlay  = 1;
    localparam int MPause = 2;
    localparam int MOver  = 3;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       tick;
    logic       gameOver;
    logic [1:0] outputState;
    logic       playEnable;
    logic       clearBoard;
    logic       holdDone;

    int n_checks;
    int n_bad;

    int         m_state;
    int         m_hold;
    logic [7:0] m_prev;
    bit         m_clear;

    game_flow_fsm #(
        .KEYCODE_W      (8),
        .KEY_START      (KStart),
        .KEY_PAUSE      (KPause),
        .KEY_RESTART    (KRestart),
        .OVER_HOLD_TICKS(Hold)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .tick       (tick),
        .gameOver   (gameOver),
        .outputState(outputState),
        .playEnable (playEnable),
        .clearBoard (clearBoard),
        .holdDone   (holdDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] screen_code(input int s);
        case (s)
            MStart:  return 2'b01;
            MPlay:   return 2'b10;
            MPause:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_state = MStart;
        m_hold  = 0;
        m_prev  = 8'h00;
        m_clear = 1'b0;
    endtask

    // One rising edge of the game-flow rules applied to the inputs seen at that edge.
    task automatic model_edge(input logic [7:0] k, input logic t, input logic go);
        bit hs, hp, hr;
        int ns;
        hs = (k == KStart)   && (m_prev != KStart);
        hp = (k == KPause)   && (m_prev != KPause);
        hr = (k == KRestart) && (m_prev != KRestart);
        ns = m_state;
        m_clear = 1'b0;
        case (m_state)
            MStart: if (hs) begin ns = MPlay; m_clear = 1'b1; end
            MPlay: begin
                if (go) begin
                    ns = MOver;
                    m_hold = Hold;
                end else if (hp) begin
                    ns = MPause;
                end
            end
            MPause: begin
                if (hr) ns = MStart;
                else if (hp) ns = MPlay;
            end
            default: begin
                if (m_hold == 0) begin
                    if (hs || hr) ns = MStart;
                end else if (t) begin
                    m_hold = m_hold - 1;
                end
            end
        endcase
        m_state = ns;
        m_prev  = k;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".screen"}, 32'(outputState), 32'(screen_code(m_state)));
        check_eq({tag, ".play"},   32'(playEnable),  32'(m_state == MPlay));
        check_eq({tag, ".clear"},  32'(clearBoard),  32'(m_clear));
        check_eq({tag, ".hold"},   32'(holdDone),    32'((m_state == MOver) && (m_hold == 0)));
    endtask

    task automatic step(input logic [7:0] k, input logic t, input logic go, input string tag);
        keycode  = k;
        tick     = t;
        gameOver = go;
        @(posedge Clk);
        model_edge(k, t, go);
        #1;
        check_all(tag);
    endtask

    // Called at posedge+1: asserts Reset mid-cycle and checks the async effect.
    task automatic async_reset(input string tag);
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] cur_key;
        logic       cur_go;
        n_checks = 0;
        n_bad    = 0;
        Reset    = 1'b1;
        keycode  = 8'h00;
        tick     = 1'b0;
        gameOver = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        check_all("reset");
        check_eq("reset.screen_const", 32'(outputState), 32'h1);
        #2;
        Reset = 1'b0;

        step(8'h00, 1'b0, 1'b0, "idle");
        step(KStart, 1'b0, 1'b0, "start");
        check_eq("start.clear_const", 32'(clearBoard), 32'h1);
        step(KStart, 1'b0, 1'b0, "start_held");
        check_eq("start_held.clear_const", 32'(clearBoard), 32'h0);
        step(8'h00, 1'b0, 1'b0, "release");
        for (int i = 0; i < 10; i++) step(KPause, 1'b0, 1'b0, "pause_held");
        check_eq("pause_once", 32'(outputState), 32'h3);
        step(8'h00, 1'b0, 1'b0, "release");
        step(KPause, 1'b0, 1'b0, "resume");
        check_eq("resume.noclear", 32'(clearBoard), 32'h0);
        step(8'h00, 1'b0, 1'b0, "release");
        // gameOver beats a pause edge; tick on the same edge must not decrement
        step(KPause, 1'b1, 1'b1, "over_vs_pause");
        check_eq("over_vs_pause.const", 32'(outputState), 32'h0);
        step(8'h00, 1'b1, 1'b0, "over_t1");
        step(KStart, 1'b0, 1'b0, "over_early_start");
        step(8'h00, 1'b1, 1'b0, "over_t2");
        step(KStart, 1'b0, 1'b0, "over_early_start2");
        check_eq("over_held", 32'(outputState), 32'h0);
        step(8'h00, 1'b1, 1'b0, "over_t3");
        check_eq("hold_done_const", 32'(holdDone), 32'h1);
        step(KRestart, 1'b0, 1'b0, "over_exit");
        check_eq("over_exit.const", 32'(outputState), 32'h1);
        step(KStart, 1'b0, 1'b0, "start2");
        step(8'h00, 1'b0, 1'b0, "release");
        step(KPause, 1'b0, 1'b0, "pause2");
        step(8'h00, 1'b0, 1'b0, "release");
        step(KRestart, 1'b0, 1'b0, "pause_restart");
        step(8'h00, 1'b0, 1'b0, "release");
        step(KStart, 1'b0, 1'b0, "start3");

        // Async reset mid-OVER with two ticks remaining, space held through release
        step(8'h00, 1'b0, 1'b1, "over2");
        step(8'h00, 1'b1, 1'b0, "over2_t1");
        keycode  = KStart;
        gameOver = 1'b0;
        async_reset("rst_mid_over");
        check_eq("rst_mid_over.screen_const", 32'(outputState), 32'h1);
        step(KStart, 1'b0, 1'b0, "post_rst_start");
        check_eq("post_rst_start.const", 32'(outputState), 32'h2);

        // Reset during the clear pulse cancels it
        step(8'h00, 1'b0, 1'b0, "release");
        step(KPause, 1'b0, 1'b0, "pause3");
        step(KRestart, 1'b0, 1'b0, "restart3");
        step(KStart, 1'b0, 1'b0, "start4");
        async_reset("rst_cancel_clear");
        check_eq("rst_cancel_clear.const", 32'(clearBoard), 32'h0);

        cur_key = 8'h00;
        cur_go  = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: cur_key = 8'h00;
                    3, 4:    cur_key = KStart;
                    5, 6:    cur_key = KPause;
                    7, 8:    cur_key = KRestart;
                    default: cur_key = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 19) == 0) cur_go = ~cur_go;
            step(cur_key, 1'($urandom_range(0, 3) == 0), cur_go, "rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/game_flow_fsm.md
# game_flow_fsm

Top-level game-flow controller for the Tetris system: a parametrised successor to the start/play/end sequencer. It adds pause/resume, restart, and a timed game-over hold. Keyboard input is edge-qualified, so a held key never retriggers. The block sits between the keyboard decoder and the game/board logic and VGA screen mux; it drives the screen-select code, the gameplay enable, and a board-clear pulse.

## Interface
Parameters:
- KEYCODE_W, 8, keycode width
- KEY_START, 8'h2C (space), starts a game from START; also exits OVER once the hold has expired
- KEY_PAUSE, 8'h13 (P), toggles PLAY/PAUSE
- KEY_RESTART, 8'h15 (R), returns to START from PAUSE or from expired OVER
- OVER_HOLD_TICKS, 120, number of frame ticks the end screen is held before keys are accepted; 0 = no hold
- Legal configuration: KEY_START, KEY_PAUSE and KEY_RESTART are pairwise distinct and non-zero

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- keycode  in  KEYCODE_W  current keyboard code; 0 = no key
- tick  in  1  one-cycle frame strobe (vsync-derived)
- gameOver  in  1  level; board logic reports top-out
- outputState  out  2  screen select: 01 start, 10 play, 11 pause, 00 end
- playEnable  out  1  high only in PLAY; gates piece gravity and movement
- clearBoard  out  1  one-cycle pulse; board logic resets the well and score
- holdDone  out  1  high in OVER once the hold counter has reached 0

## Operation
- Key edge: `hit_K = (keycode == K) && (prev_key != K)`.
  - prev_key is a KEYCODE_W register of keycode.
  - Reset value of prev_key is 0.
- States: START, PLAY, PAUSE, OVER. Reset state is START.
- START:
  - hit_START -> PLAY.
  - All other inputs are ignored, including gameOver.
- PLAY, in priority order:
  - gameOver=1 -> OVER. This wins over a hit_PAUSE in the same cycle.
  - hit_PAUSE -> PAUSE.
  - hit_RESTART is ignored.
- PAUSE, in priority order:
  - hit_RESTART -> START.
  - hit_PAUSE -> PLAY.
  - gameOver is ignored. It is re-evaluated on the first PLAY cycle.
- OVER:
  - While hold_cnt != 0, all keys are ignored.
  - Once hold_cnt == 0, hit_START or hit_RESTART -> START.
  - OVER stays OVER regardless of gameOver.
- hold_cnt:
  - Width is `$clog2(OVER_HOLD_TICKS+1)`, minimum 1.
  - Loaded with OVER_HOLD_TICKS on the transition PLAY->OVER.
  - Decrements by 1 on each tick while in OVER and nonzero; saturates at 0.
  - Does not change outside OVER.
- Outputs:
  - outputState is a combinational decode of the state register; playEnable = (state==PLAY).
  - holdDone = (state==OVER) && (hold_cnt==0).
  - clearBoard is registered. It is high for exactly the first cycle in PLAY after a START->PLAY transition. Resume from PAUSE does not assert it.
- Reset values: outputState=01, playEnable=0, clearBoard=0, holdDone=0, hold_cnt=0, prev_key=0.
- Reset mid-operation, from any state: the block returns to START immediately and asynchronously. Any clearBoard pulse is cancelled. A key still held through reset deassertion counts as a new edge only if prev_key (0) differs from it. Example: space held through reset -> PLAY on the first clock after release of Reset.

## Timing
- Key edge sampled at rising edge N: state updates at edge N. outputState and playEnable reflect the new state in cycle N+1; this is 1-cycle latency.
- clearBoard is high during cycle N+1 only. It coincides with the first playEnable=1 cycle.
- gameOver sampled high at edge N in PLAY: playEnable drops in cycle N+1.
- Hold: OVER is entered at edge E. After OVER_HOLD_TICKS tick pulses, holdDone rises the cycle after the edge that consumed the last tick. The earliest exit is on the following key edge.
  - OVER_HOLD_TICKS=0: holdDone=1 from the first OVER cycle.
- A tick coinciding with the PLAY->OVER transition edge does not decrement; the load takes priority.
- A held key produces exactly one transition. Changing to another key and back produces a new edge.

## Test plan
- Reset, then keycode=2C for 1 cycle -> outputState 01->10 next cycle, clearBoard=1 for 1 cycle, playEnable=1.
- In PLAY, keycode=13 held 10 cycles -> PAUSE (11) once, no toggle back. Release, then 13 again -> PLAY (10), clearBoard stays 0.
- In PLAY, gameOver=1 and keycode edge 13 in the same cycle -> OVER (00), not PAUSE. playEnable=0 next cycle.
- OVER_HOLD_TICKS=3: in OVER press 2C before the 3rd tick -> stays 00. After the 3rd tick holdDone=1, press 15 -> START (01).
- In PAUSE press 15 -> START (01), no clearBoard. Then 2C -> PLAY with clearBoard pulse.
- Assert Reset asynchronously mid-OVER (hold_cnt=2) -> outputState=01, holdDone=0 without a clock edge. Space held through release -> PLAY on the first post-reset edge.
